// File: rtl/mems_spi_pkg.sv
// rtl/mems_spi_pkg.sv - shared types and constants for the MEMS mirror DAC SPI path
package mems_spi_pkg;

  localparam int WORD_W_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SETUP = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // DAC command word fields
  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 19;
  localparam int ADDR_MSB = 18;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/mems_spi_tick.sv
// rtl/mems_spi_tick.sv - CLK_DIV half-period tick generator with synchronous clear
module mems_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  assign o_tick = (r_cnt == TERM);

  // Counter never exceeds CLK_DIV-1, so 8 bits cover CLK_DIV=255 with no wrap.
  always_ff @(posedge clk) begin
    if (rst || i_clr || o_tick) r_cnt <= 8'd0;
    else                        r_cnt <= r_cnt + 8'd1;
  end

endmodule

// File: rtl/mems_spi_tx.sv
// rtl/mems_spi_tx.sv - ROM-fed 24-bit SPI frame transmitter for the quad mirror DAC
module mems_spi_tx
  import mems_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int WORD_W  = WORD_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              sync_n
);

  localparam int         BW       = $clog2(WORD_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W);
  localparam logic [1:0] LAT_TERM = 2'(ROM_LAT - 1);

  state_t            r_state;
  logic [1:0]        r_fcnt;
  logic [BW-1:0]     r_bitcnt;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] w_shift_next;
  logic              w_tick;
  logic              w_tick_clr;

  // Restart the half-period timer so the first SETUP interval is a full CLK_DIV.
  assign w_tick_clr   = (r_state == ST_FETCH) && (r_fcnt == LAT_TERM);
  assign w_shift_next = r_shreg << 1;

  mems_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tick_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_fcnt   <= 2'd0;
      r_bitcnt <= '0;
      r_shreg  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b1;
      mosi     <= 1'b0;
      sync_n   <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            busy    <= 1'b1;
            r_fcnt  <= 2'd0;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (r_fcnt == LAT_TERM) begin
            r_shreg <= rom_data;
            mosi    <= rom_data[WORD_W-1];
            sync_n  <= 1'b0;
            r_state <= ST_SETUP;
          end else begin
            r_fcnt <= r_fcnt + 2'd1;
          end
        end
        ST_SETUP: begin
          if (w_tick) begin
            sclk     <= 1'b0;
            r_bitcnt <= BW'(1);
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (sclk) begin
              sclk     <= 1'b0;
              r_bitcnt <= r_bitcnt + BW'(1);
            end else if (r_bitcnt == LAST_BIT) begin
              // Final rise closes the frame together with sync_n.
              sclk    <= 1'b1;
              sync_n  <= 1'b1;
              mosi    <= 1'b0;
              r_state <= ST_GAP;
            end else begin
              sclk    <= 1'b1;
              r_shreg <= w_shift_next;
              mosi    <= w_shift_next[WORD_W-1];
            end
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            r_bitcnt <= '0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mems_spi_tx.sv
// tb/tb_mems_spi_tx.sv - directed self-checking bench for mems_spi_tx
module tb_mems_spi_tx;
  import mems_spi_pkg::*;

  localparam int R = 1;

  logic        clk;
  logic        rst;
  logic [2:0]  start_v;
  logic [23:0] rom_v [3];
  logic [2:0]  busy_v, done_v, sclk_v, mosi_v, sync_v;

  int checks;
  int errors;
  int hi_run;
  int last_hi_run;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mems_spi_tx #(.CLK_DIV(4), .WORD_W(WORD_W_DEF), .ROM_LAT(R)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .rom_data(rom_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .sync_n(sync_v[0]));
  mems_spi_tx #(.CLK_DIV(1), .WORD_W(WORD_W_DEF), .ROM_LAT(R)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .rom_data(rom_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .sync_n(sync_v[1]));
  mems_spi_tx #(.CLK_DIV(255), .WORD_W(WORD_W_DEF), .ROM_LAT(R)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .rom_data(rom_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .sync_n(sync_v[2]));

  // Length of the most recent completed sync_n-high stretch on instance 0.
  always @(negedge clk) begin
    if (sync_v[0] === 1'b1) hi_run = hi_run + 1;
    else begin
      if (hi_run != 0) last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  task automatic kick(input int idx, input logic [23:0] word);
    rom_v[idx]   = word;
    start_v[idx] = 1'b1;
    @(negedge clk);
  endtask

  // Entered one half-cycle after the edge that sampled start (t=0).
  task automatic watch(input int idx, input int c, input logic [23:0] exp, input string nm,
                       input int extra_t, input bit chain, input logic [23:0] nword);
    int t, falls, badt, busyc, syncl, stray, limit;
    bit got_done;
    logic [23:0] cap;
    logic psclk, psync;
    t = 0; falls = 0; badt = 0; busyc = 0; syncl = 0; stray = 0;
    got_done = 0; cap = '0; psclk = 1'b1; psync = 1'b1;
    limit = 49 * c + R + 10;
    checks++;
    if (busy_v[idx] !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_start got %b want 1", nm, busy_v[idx]);
    end
    forever begin
      if (busy_v[idx] === 1'b1) busyc++;
      if (sync_v[idx] === 1'b0) syncl++;
      if (sclk_v[idx] !== psclk && sync_v[idx] === 1'b1 && psync === 1'b1) stray++;
      if (psclk === 1'b1 && sclk_v[idx] === 1'b0) begin
        falls++;
        cap = {cap[22:0], mosi_v[idx]};
        if (t != R + c * (2 * falls - 1)) badt++;
        if (sync_v[idx] !== 1'b0) stray++;
      end
      psclk = sclk_v[idx];
      psync = sync_v[idx];
      if (done_v[idx] === 1'b1) begin got_done = 1; break; end
      if (t >= limit) break;
      start_v[idx] = (t == extra_t - 1);
      if (t == R + 1) rom_v[idx] = ~exp;
      @(negedge clk);
      t++;
    end
    checks++;
    if (!got_done) begin
      errors++; $display("FAIL %s done_timeout got t=%0d want done by %0d", nm, t, limit);
    end
    checks++;
    if (t != 49 * c + R) begin
      errors++; $display("FAIL %s done_time got %0d want %0d", nm, t, 49 * c + R);
    end
    checks++;
    if (falls != 24) begin
      errors++; $display("FAIL %s fall_count got %0d want 24", nm, falls);
    end
    checks++;
    if (badt != 0) begin
      errors++; $display("FAIL %s fall_timing got %0d misplaced want 0", nm, badt);
    end
    checks++;
    if (cap !== exp) begin
      errors++; $display("FAIL %s word got %h want %h", nm, cap, exp);
    end
    checks++;
    if (busyc != 49 * c + R) begin
      errors++; $display("FAIL %s busy_len got %0d want %0d", nm, busyc, 49 * c + R);
    end
    checks++;
    if (syncl != 48 * c) begin
      errors++; $display("FAIL %s sync_low_len got %0d want %0d", nm, syncl, 48 * c);
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL %s edges_outside_frame got %0d want 0", nm, stray);
    end
    if (chain) begin
      rom_v[idx]   = nword;
      start_v[idx] = 1'b1;
      @(negedge clk);
    end else begin
      start_v[idx] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_v[idx] !== 1'b0 || busy_v[idx] !== 1'b0) begin
        errors++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", nm, done_v[idx], busy_v[idx]);
      end
    end
  endtask

  task automatic test_reset;
    int bad_done;
    bad_done = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_v !== 3'b000) bad_done++;
    end
    checks++;
    if (busy_v !== 3'b000 || sync_v !== 3'b111 || sclk_v !== 3'b111 || mosi_v !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle got busy=%b sync=%b sclk=%b mosi=%b want 000 111 111 000",
               busy_v, sync_v, sclk_v, mosi_v);
    end
    checks++;
    if (bad_done != 0) begin
      errors++; $display("FAIL reset_no_done got %0d pulses want 0", bad_done);
    end
  endtask

  task automatic test_single;
    kick(0, 24'h3F8000);
    watch(0, 4, 24'h3F8000, "single", -1, 1'b0, 24'h0);
  endtask

  task automatic test_busy_handshake;
    kick(0, 24'hC30F1E);
    watch(0, 4, 24'hC30F1E, "handshake", 5, 1'b0, 24'h0);
  endtask

  task automatic test_back_to_back;
    kick(0, 24'hA5A5A5);
    watch(0, 4, 24'hA5A5A5, "b2b_first", -1, 1'b1, 24'h5A5A5A);
    watch(0, 4, 24'h5A5A5A, "b2b_second", -1, 1'b0, 24'h0);
    checks++;
    if (last_hi_run != 4 + 1 + R) begin
      errors++; $display("FAIL b2b_gap got %0d want %0d", last_hi_run, 4 + 1 + R);
    end
  endtask

  task automatic test_reset_mid_frame;
    int falls, guard, bad_done;
    logic psclk;
    falls = 0; guard = 0; bad_done = 0; psclk = 1'b1;
    kick(0, 24'hFEDCBA);
    start_v[0] = 1'b0;
    while (falls < 10 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (psclk === 1'b1 && sclk_v[0] === 1'b0) falls++;
      psclk = sclk_v[0];
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (falls != 10 || sync_v[0] !== 1'b1 || sclk_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got falls=%0d sync=%b sclk=%b busy=%b done=%b want 10 1 1 0 0",
               falls, sync_v[0], sclk_v[0], busy_v[0], done_v[0]);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done != 0) begin
      errors++; $display("FAIL reset_mid_quiet got %0d bad cycles want 0", bad_done);
    end
    kick(0, 24'h123456);
    watch(0, 4, 24'h123456, "after_reset", -1, 1'b0, 24'h0);
  endtask

  task automatic test_param_corners;
    kick(1, 24'hFFFFFF);
    watch(1, 1, 24'hFFFFFF, "div1", -1, 1'b0, 24'h0);
    kick(2, 24'h000001);
    watch(2, 255, 24'h000001, "div255", -1, 1'b0, 24'h0);
  endtask

  initial begin
    checks = 0; errors = 0; hi_run = 0; last_hi_run = 0;
    rst = 1'b1;
    start_v = 3'b000;
    for (int i = 0; i < 3; i++) rom_v[i] = 24'h0;
    @(negedge clk);
    test_reset();
    test_single();
    test_busy_handshake();
    test_back_to_back();
    test_reset_mid_frame();
    test_param_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
